// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch block.
//   fetch_state_e : fetch FSM state encoding (IDLE, RUN, HALT)
//   PC_W          : word-address width of the instruction memory
//   INSTR_W       : instruction width
//   NOP_INSTR     : all-zero word; it halts fetch when FETCH_HALT_ON_ZERO_EN is defined
//   pc_next()     : PC increment, wraps modulo 2**PC_W
package fetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // 255 -> 0 carries out of the top bit and the carry is dropped; no flag.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry output register between fetch and decode.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : capture in_instruction/in_pc and mark the entry valid
//   flush           : drop the entry (valid -> 0); wins over load
//   ready           : downstream accepts the entry when valid && ready
//   in_instruction  : instruction to capture
//   in_pc           : address of in_instruction
//   valid           : entry holds an instruction
//   instruction, pc : held instruction and its address
module fetch_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic [PC_W-1:0]    in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else if (flush) begin
      // Data is left in place; only valid matters once flushed.
      valid <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      instruction <= in_instruction;
      pc          <= in_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing and fetch FSM feeding a single-entry
// instruction buffer toward decode. The instruction memory is combinational:
// imem_instruction answers imem_pc in the same cycle.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN -- an all-zero fetched word
// halts fetch instead of being delivered.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   start                           : leave IDLE and begin fetching
//   imem_pc / imem_instruction      : instruction memory address / data
//   if_valid/if_instruction/if_pc   : fetched instruction toward decode
//   id_ready                        : decode accepts when if_valid && id_ready
//   redirect / redirect_pc          : taken branch/jump and its target
//   busy / halted                   : state is RUN / state is HALT
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; waits for start, PC holds, redirect ignored
// RUN   | fetching one word per accepted slot
// HALT  | zero word seen (macro builds only); waits for redirect
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic               halted
);

  fetch_state_e state, state_nxt;
  logic [PC_W-1:0] pc;

  logic redirect_take;
  logic fetch_slot;
  logic zero_hit;
  logic capture;

  // Redirect only acts once fetching has been started.
  assign redirect_take = redirect && (state != IDLE);

  // A fetch slot exists when the buffer is empty or being drained this edge.
  assign fetch_slot = (state == RUN) && !redirect && (!if_valid || id_ready);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = fetch_slot && (imem_instruction == NOP_INSTR);
`else
  assign zero_hit = 1'b0;
`endif

  assign capture = fetch_slot && !zero_hit;

  assign imem_pc = pc;

  // PC register: redirect beats capture; a zero-word halt leaves PC on that word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_take) begin
      pc <= redirect_pc;
    end else if (capture) begin
      pc <= pc_next(pc);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (redirect)      state_nxt = RUN;
        else if (zero_hit) state_nxt = HALT;
      end
      HALT: if (redirect) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN);
`ifdef FETCH_HALT_ON_ZERO_EN
    halted = (state == HALT);
`else
    halted = 1'b0;
`endif
  end

  // A zero-word halt flushes too, so the buffer is empty while halted even
  // when the previous entry is being accepted on that same edge.
  fetch_buf u_fetch_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (capture),
    .flush          (redirect_take || zero_hit),
    .ready          (id_ready),
    .in_instruction (imem_instruction),
    .in_pc          (pc),
    .valid          (if_valid),
    .instruction    (if_instruction),
    .pc             (if_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_pc;
  logic [31:0] imem_instruction;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [7:0]  if_pc;
  logic        id_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        busy;
  logic        halted;

  int vectors = 0;
  int errors  = 0;
  int accept5 = 0;

  fetch_controller #(.RESET_PC(8'd0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .id_ready         (id_ready),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .busy             (busy),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word i = 0xA500_0000 | i, except word 14 is all-zero.
  function automatic logic [31:0] word(input logic [7:0] a);
    return (a == 8'd14) ? 32'h0 : (32'hA500_0000 | {24'h0, a});
  endfunction

  assign imem_instruction = word(imem_pc);

  // Acceptance of word 5 must never happen (it is flushed while stalled).
  always @(posedge clk)
    if (rst_n && if_valid && id_ready && if_pc == 8'd5) accept5++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] p, input logic [7:0] ipc);
    chk({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, v});
    if (v) begin
      chk({tag, ".if_pc"}, {24'h0, if_pc}, {24'h0, p});
      chk({tag, ".if_instruction"}, if_instruction, word(p));
    end
    chk({tag, ".imem_pc"}, {24'h0, imem_pc}, {24'h0, ipc});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'd0;
    step(); step();
    chk("rst.if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst.if_pc", {24'h0, if_pc}, 32'h0);
    chk("rst.if_instruction", if_instruction, 32'h0);
    chk("rst.imem_pc", {24'h0, imem_pc}, 32'h0);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);

    rst_n = 1'b1;
    step();
    // redirect in IDLE is ignored
    redirect = 1'b1; redirect_pc = 8'd40;
    step();
    redirect = 1'b0;
    chk("idle_redir.busy", {31'h0, busy}, 32'h0);
    chk_out("idle_redir", 1'b0, 8'd0, 8'd0);

    // start together with redirect acts as start only
    start = 1'b1; redirect = 1'b1; redirect_pc = 8'd40;
    step();
    start = 1'b0; redirect = 1'b0;
    chk("start.busy", {31'h0, busy}, 32'h1);
    chk_out("start", 1'b0, 8'd0, 8'd0);
    step(); chk_out("seq0", 1'b1, 8'd0, 8'd1);
    step(); chk_out("seq1", 1'b1, 8'd1, 8'd2);

    // stall three cycles on word 1
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall", 1'b1, 8'd1, 8'd2);
    end
    id_ready = 1'b1;
    step(); chk_out("release2", 1'b1, 8'd2, 8'd3);
    step(); chk_out("seq3", 1'b1, 8'd3, 8'd4);
    step(); chk_out("seq4", 1'b1, 8'd4, 8'd5);
    step(); chk_out("seq5", 1'b1, 8'd5, 8'd6);

    // redirect while stalled on word 5
    id_ready = 1'b0;
    step(); chk_out("stall5", 1'b1, 8'd5, 8'd6);
    redirect = 1'b1; redirect_pc = 8'd40;
    step();
    redirect = 1'b0;
    chk_out("flush", 1'b0, 8'd0, 8'd40);
    step(); chk_out("target40", 1'b1, 8'd40, 8'd41);
    chk("no_accept5", accept5, 32'd0);

    // wrap 254 -> 255 -> 0 -> 1
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'd254;
    step();
    redirect = 1'b0;
    chk_out("wrap_flush", 1'b0, 8'd0, 8'd254);
    step(); chk_out("wrap254", 1'b1, 8'd254, 8'd255);
    step(); chk_out("wrap255", 1'b1, 8'd255, 8'd0);
    step(); chk_out("wrap0", 1'b1, 8'd0, 8'd1);
    step(); chk_out("wrap1", 1'b1, 8'd1, 8'd2);

    // zero word at address 14
    redirect = 1'b1; redirect_pc = 8'd10;
    step();
    redirect = 1'b0;
    step(); chk_out("z10", 1'b1, 8'd10, 8'd11);
    step(); chk_out("z11", 1'b1, 8'd11, 8'd12);
    step(); chk_out("z12", 1'b1, 8'd12, 8'd13);
    step(); chk_out("z13", 1'b1, 8'd13, 8'd14);
    step();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt.halted", {31'h0, halted}, 32'h1);
    chk("halt.busy", {31'h0, busy}, 32'h0);
    chk_out("halt", 1'b0, 8'd0, 8'd14);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("halt_hold.halted", {31'h0, halted}, 32'h1);
    chk_out("halt_hold", 1'b0, 8'd0, 8'd14);
    redirect = 1'b1; redirect_pc = 8'd0;
    step();
    redirect = 1'b0;
    chk("unhalt.busy", {31'h0, busy}, 32'h1);
    chk("unhalt.halted", {31'h0, halted}, 32'h0);
    chk_out("unhalt", 1'b0, 8'd0, 8'd0);
    step(); chk_out("unhalt0", 1'b1, 8'd0, 8'd1);
`else
    chk("zero.halted", {31'h0, halted}, 32'h0);
    chk_out("zero14", 1'b1, 8'd14, 8'd15);
    chk("zero14.instr", if_instruction, 32'h0);
    step(); chk_out("zero15", 1'b1, 8'd15, 8'd16);
`endif

    // reset mid-run, with start asserted to show reset wins
    chk("pre_rst.if_valid", {31'h0, if_valid}, 32'h1);
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    chk("mrst.busy", {31'h0, busy}, 32'h0);
    chk("mrst.halted", {31'h0, halted}, 32'h0);
    chk("mrst.if_pc", {24'h0, if_pc}, 32'h0);
    chk("mrst.if_instruction", if_instruction, 32'h0);
    chk_out("mrst", 1'b0, 8'd0, 8'd0);
    step(); step();
    chk("idle_after.busy", {31'h0, busy}, 32'h0);
    chk_out("idle_after", 1'b0, 8'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_out("restart0", 1'b1, 8'd0, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
